// File: rtl/bsg_tag_tx_pkg.sv
// Shared types and helpers for the bsg_tag serial transmitter.
// Pure package: no timing or flow-control behaviour of its own.
package bsg_tag_tx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        GAP      = 2'd2,
        PREAMBLE = 2'd3
    } bsg_tag_tx_state_e;

    // Width helper that never returns zero, so single-element fields still get a bit.
    function automatic int bsg_tag_tx_safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    // Bits on the wire: start + node_id + data_not_reset + len + payload.
    function automatic int bsg_tag_tx_pkt_len(input int lg_els, input int lg_width, input int len);
        return 2 + lg_els + lg_width + len;
    endfunction

endpackage

// File: rtl/bsg_tag_tx_piso.sv
// Parallel-load, LSB-first shift register; lsb is the next bit to transmit.
// Latency: load/shift take effect on the next clk edge; no backpressure (caller sequences enables).
module bsg_tag_tx_piso #(
    parameter int width_p = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               shift,
    input  logic [width_p-1:0] load_data,
    output logic               lsb
);

    logic [width_p-1:0] sreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= load_data;
        end else if (shift) begin
            sreg <= {1'b0, sreg[width_p-1:1]};
        end
    end

    assign lsb = sreg[0];

endmodule

// File: rtl/bsg_tag_tx.sv
// bsg_tag serializer: one packet per v_i/ready_and_o handshake, start bit one cycle after accept, one gap cycle after.
// Backpressure: ready_and_o only in IDLE; optional reset preamble under BSG_TAG_TX_RESET_PREAMBLE_EN.
module bsg_tag_tx
    import bsg_tag_tx_pkg::*;
#(
    parameter int tag_els_p               = 16,
    parameter int tag_max_payload_width_p = 10,
    parameter int preamble_len_p          = 64,
    localparam int lg_els   = bsg_tag_tx_safe_clog2(tag_els_p),
    localparam int lg_width = bsg_tag_tx_safe_clog2(tag_max_payload_width_p + 1)
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               v_i,
    output logic                               ready_and_o,
    input  logic [lg_els-1:0]                  node_id_i,
    input  logic                               data_not_reset_i,
    input  logic [lg_width-1:0]                len_i,
    input  logic [tag_max_payload_width_p-1:0] payload_i,
    output logic                               tag_data_o,
    output logic                               tag_en_o,
    output logic                               busy_o
);

    localparam int pkt_w = 2 + lg_els + lg_width + tag_max_payload_width_p;
    localparam int cnt_w = bsg_tag_tx_safe_clog2(pkt_w + 1);
    localparam logic [lg_width-1:0] max_len = lg_width'(tag_max_payload_width_p);

`ifdef BSG_TAG_TX_RESET_PREAMBLE_EN
    localparam bsg_tag_tx_state_e reset_state = PREAMBLE;
    localparam int pcnt_w = bsg_tag_tx_safe_clog2(preamble_len_p + 1);
    logic [pcnt_w-1:0] pcnt, pcnt_n;
`else
    localparam bsg_tag_tx_state_e reset_state = IDLE;
`endif

    bsg_tag_tx_state_e state, state_n;
    logic [cnt_w-1:0]  cnt, cnt_n;
    logic              data_q, data_n;
    logic              en_q, en_n;
    logic              load, shift, piso_bit, accept;
    logic [lg_width-1:0] len_c;
    logic [pkt_w-1:0]    pkt_vec;

    assign len_c   = (len_i > max_len) ? max_len : len_i;
    assign pkt_vec = {payload_i, len_c, data_not_reset_i, node_id_i, 1'b1};

    assign ready_and_o = (state == IDLE) & ~reset_i;
    assign busy_o      = reset_i | (state != IDLE);
    assign accept      = v_i & ready_and_o;
    assign tag_data_o  = data_q;
    assign tag_en_o    = en_q;

    // The start bit goes straight to the output flop at accept, so the shifter holds bits 1..L-1.
    bsg_tag_tx_piso #(.width_p(pkt_w)) piso (
        .clk       (clk_i),
        .reset     (reset_i),
        .load      (load),
        .shift     (shift),
        .load_data (pkt_vec >> 1),
        .lsb       (piso_bit)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        data_n  = 1'b0;
        en_n    = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
`ifdef BSG_TAG_TX_RESET_PREAMBLE_EN
        pcnt_n  = pcnt;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    data_n  = 1'b1;
                    en_n    = 1'b1;
                    cnt_n   = cnt_w'(bsg_tag_tx_pkt_len(lg_els, lg_width, int'(len_c)) - 1);
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                // cnt counts bits still to be placed on the line after the current one.
                if (cnt != '0) begin
                    data_n = piso_bit;
                    en_n   = 1'b1;
                    shift  = 1'b1;
                    cnt_n  = cnt - 1'b1;
                end else begin
                    state_n = GAP;
                end
            end
            GAP: state_n = IDLE;
            PREAMBLE: begin
`ifdef BSG_TAG_TX_RESET_PREAMBLE_EN
                if (pcnt != '0) begin
                    data_n = 1'b1;
                    en_n   = 1'b1;
                    pcnt_n = pcnt - 1'b1;
                end else begin
                    state_n = GAP;
                end
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state  <= reset_state;
            cnt    <= '0;
            data_q <= 1'b0;
            en_q   <= 1'b0;
`ifdef BSG_TAG_TX_RESET_PREAMBLE_EN
            pcnt   <= pcnt_w'(preamble_len_p);
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            data_q <= data_n;
            en_q   <= en_n;
`ifdef BSG_TAG_TX_RESET_PREAMBLE_EN
            pcnt   <= pcnt_n;
`endif
        end
    end

endmodule
